// File: rtl/axi4_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// axi4_burst_addr_gen
//
// Per-beat address / byte-strobe generator for AXI4 bursts. One AW/AR-style
// command is accepted on the cmd_* handshake; the block then issues one
// handshaked beat descriptor per transfer (address, strobe, index, last).
// FIXED, INCR and WRAP bursts are supported. Illegal commands are consumed
// and answered with a one-cycle cmd_err pulse and no beats.
//
// Parameters
//   ADDRESS_WIDTH  width of command and beat addresses
//   DATA_WIDTH     data bus width in bits (power of two, 8..1024)
//   LENGTH         width of the burst length field (beats = len + 1)
//
// Ports
//   aclk, aresetn                 clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready         command handshake
//   cmd_addr, cmd_len,
//   cmd_size, cmd_burst           command fields (AxADDR/AxLEN/AxSIZE/AxBURST)
//   beat_valid / beat_ready       beat descriptor handshake
//   beat_addr, beat_strb,
//   beat_idx, beat_last           current beat descriptor
//   cmd_err                       one-cycle pulse: accepted command was illegal
//   busy                          burst in progress
//
// Optional build macro
//   AXI4_BURST_4KB_CHECK_EN  when defined, an INCR burst whose last byte falls
//                            in a different 4 KB page than cmd_addr is
//                            rejected with cmd_err. When undefined, such
//                            bursts are generated linearly across the page.
// -----------------------------------------------------------------------------
module axi4_burst_addr_gen #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LENGTH        = 8
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0]   cmd_addr,
  input  logic [LENGTH-1:0]          cmd_len,
  input  logic [2:0]                 cmd_size,
  input  logic [1:0]                 cmd_burst,
  output logic                       beat_valid,
  input  logic                       beat_ready,
  output logic [ADDRESS_WIDTH-1:0]   beat_addr,
  output logic [DATA_WIDTH/8-1:0]    beat_strb,
  output logic [LENGTH-1:0]          beat_idx,
  output logic                       beat_last,
  output logic                       cmd_err,
  output logic                       busy
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK = ADDRESS_WIDTH'(STRB_W - 1);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Address helpers
  // ---------------------------------------------------------------------------
  function automatic logic [ADDRESS_WIDTH-1:0] size_bytes(input logic [2:0] size);
    return ADDR_ONE << size;
  endfunction

  function automatic logic [ADDRESS_WIDTH-1:0] align_down(
    input logic [ADDRESS_WIDTH-1:0] addr,
    input logic [2:0]               size
  );
    return addr & ~(size_bytes(size) - ADDR_ONE);
  endfunction

  // Lanes lo..hi: lo is the byte lane of the address itself, hi is the last
  // lane of the size-aligned container. An unaligned address therefore only
  // enables the tail of its container.
  function automatic logic [STRB_W-1:0] lane_strb(
    input logic [ADDRESS_WIDTH-1:0] addr,
    input logic [2:0]               size
  );
    logic [ADDRESS_WIDTH-1:0] lo;
    logic [ADDRESS_WIDTH-1:0] hi;
    logic [STRB_W-1:0]        strb;
    lo = addr & LANE_MASK;
    hi = (align_down(addr, size) & LANE_MASK) + size_bytes(size) - ADDR_ONE;
    for (int i = 0; i < STRB_W; i++) begin
      strb[i] = (ADDRESS_WIDTH'(i) >= lo) && (ADDRESS_WIDTH'(i) <= hi);
    end
    return strb;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                     state_r,      state_nxt_s;
  logic                       ready_r,      ready_nxt_s;
  logic                       err_r,        err_nxt_s;
  logic                       beat_valid_r, beat_valid_nxt_s;
  logic [ADDRESS_WIDTH-1:0]   beat_addr_r,  beat_addr_nxt_s;
  logic [STRB_W-1:0]          beat_strb_r,  beat_strb_nxt_s;
  logic [LENGTH-1:0]          beat_idx_r,   beat_idx_nxt_s;
  logic                       beat_last_r,  beat_last_nxt_s;
  logic [1:0]                 burst_r,      burst_nxt_s;
  logic [2:0]                 size_r,       size_nxt_s;
  logic [LENGTH-1:0]          len_r,        len_nxt_s;
  logic [ADDRESS_WIDTH-1:0]   wrap_lower_r, wrap_lower_nxt_s;
  logic [ADDRESS_WIDTH-1:0]   wrap_bound_r, wrap_bound_nxt_s;

  logic                       cmd_fire_s;
  logic                       beat_fire_s;
  logic                       cmd_illegal_s;
  logic                       load_s;
  logic                       page_cross_s;
  logic                       wrap_len_ok_s;
  logic [ADDRESS_WIDTH-1:0]   cmd_bytes_s;
  logic [ADDRESS_WIDTH-1:0]   cmd_wsize_s;
  logic [ADDRESS_WIDTH-1:0]   cmd_wrap_lower_s;

  logic [ADDRESS_WIDTH-1:0]   step_bytes_s;
  logic [ADDRESS_WIDTH-1:0]   wrap_step_s;
  logic [ADDRESS_WIDTH-1:0]   next_addr_s;
  logic [STRB_W-1:0]          next_strb_s;
  logic [LENGTH-1:0]          next_idx_s;

  // cmd_ready is registered except for one term: during the final beat the
  // slot frees up in the same cycle the consumer takes it, which is what lets
  // a following command start with no bubble.
  assign beat_fire_s = beat_valid_r && beat_ready;
  assign cmd_ready   = ready_r || (beat_fire_s && beat_last_r);
  assign cmd_fire_s  = cmd_valid && cmd_ready;
  assign load_s      = cmd_fire_s && !cmd_illegal_s;

  assign beat_valid = beat_valid_r;
  assign beat_addr  = beat_addr_r;
  assign beat_strb  = beat_strb_r;
  assign beat_idx   = beat_idx_r;
  assign beat_last  = beat_last_r;
  assign cmd_err    = err_r;
  assign busy       = (state_r == S_BURST);

`ifdef AXI4_BURST_4KB_CHECK_EN
  logic [ADDRESS_WIDTH-1:0] incr_last_byte_s;

  // Page-crossing detection for INCR: compare the 4 KB page of the last byte
  // of the burst against the page of the start address.
  always_comb begin
    incr_last_byte_s = align_down(cmd_addr, cmd_size)
                     + ((ADDRESS_WIDTH'(cmd_len) + ADDR_ONE) << cmd_size)
                     - ADDR_ONE;
    if (cmd_burst == BURST_INCR) begin
      page_cross_s = (incr_last_byte_s >> 4'd12) != (cmd_addr >> 4'd12);
    end else begin
      page_cross_s = 1'b0;
    end
  end
`else
  assign page_cross_s = 1'b0;
`endif

  // Command legality check and WRAP window geometry of the offered command.
  always_comb begin
    cmd_bytes_s      = size_bytes(cmd_size);
    cmd_wsize_s      = (ADDRESS_WIDTH'(cmd_len) + ADDR_ONE) << cmd_size;
    cmd_wrap_lower_s = cmd_addr & ~(cmd_wsize_s - ADDR_ONE);
    wrap_len_ok_s    = (cmd_len == LENGTH'(1)) || (cmd_len == LENGTH'(3)) ||
                       (cmd_len == LENGTH'(7)) || (cmd_len == LENGTH'(15));
    if (cmd_burst == BURST_RSVD) begin
      cmd_illegal_s = 1'b1;
    end else if (cmd_size > MAX_SIZE) begin
      cmd_illegal_s = 1'b1;
    end else if ((cmd_burst == BURST_WRAP) && !wrap_len_ok_s) begin
      cmd_illegal_s = 1'b1;
    end else if ((cmd_burst == BURST_WRAP) &&
                 ((cmd_addr & (cmd_bytes_s - ADDR_ONE)) != '0)) begin
      cmd_illegal_s = 1'b1;
    end else begin
      cmd_illegal_s = page_cross_s;
    end
  end

  // Descriptor of the beat that follows the one currently presented.
  always_comb begin
    step_bytes_s = size_bytes(size_r);
    wrap_step_s  = beat_addr_r + step_bytes_s;
    next_addr_s  = beat_addr_r;
    case (burst_r)
      BURST_FIXED: next_addr_s = beat_addr_r;
      // Realigning each step makes beat n = aligned + n*bytes even when
      // beat 0 was unaligned.
      BURST_INCR:  next_addr_s = align_down(beat_addr_r, size_r) + step_bytes_s;
      BURST_WRAP: begin
        if (wrap_step_s == wrap_bound_r) begin
          next_addr_s = wrap_lower_r;
        end else begin
          next_addr_s = wrap_step_s;
        end
      end
      default:     next_addr_s = beat_addr_r;
    endcase
    if (burst_r == BURST_FIXED) begin
      next_strb_s = beat_strb_r;
    end else begin
      next_strb_s = lane_strb(next_addr_s, size_r);
    end
    next_idx_s = beat_idx_r + LENGTH'(1);
  end

  // FSM next-state and next values for every registered output.
  always_comb begin
    state_nxt_s      = state_r;
    ready_nxt_s      = ready_r;
    err_nxt_s        = cmd_fire_s && cmd_illegal_s;
    beat_valid_nxt_s = beat_valid_r;
    beat_addr_nxt_s  = beat_addr_r;
    beat_strb_nxt_s  = beat_strb_r;
    beat_idx_nxt_s   = beat_idx_r;
    beat_last_nxt_s  = beat_last_r;
    burst_nxt_s      = burst_r;
    size_nxt_s       = size_r;
    len_nxt_s        = len_r;
    wrap_lower_nxt_s = wrap_lower_r;
    wrap_bound_nxt_s = wrap_bound_r;

    if (load_s) begin
      beat_addr_nxt_s  = cmd_addr;
      beat_strb_nxt_s  = lane_strb(cmd_addr, cmd_size);
      beat_idx_nxt_s   = {LENGTH{1'b0}};
      beat_last_nxt_s  = (cmd_len == {LENGTH{1'b0}});
      burst_nxt_s      = cmd_burst;
      size_nxt_s       = cmd_size;
      len_nxt_s        = cmd_len;
      wrap_lower_nxt_s = cmd_wrap_lower_s;
      wrap_bound_nxt_s = cmd_wrap_lower_s + cmd_wsize_s;
    end else begin
      beat_addr_nxt_s  = beat_addr_r;
    end

    case (state_r)
      S_IDLE: begin
        if (load_s) begin
          state_nxt_s      = S_BURST;
          ready_nxt_s      = 1'b0;
          beat_valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s      = S_IDLE;
          ready_nxt_s      = 1'b1;
          beat_valid_nxt_s = 1'b0;
        end
      end
      S_BURST: begin
        if (load_s) begin
          // Back-to-back: new command taken during the final beat.
          state_nxt_s      = S_BURST;
          ready_nxt_s      = 1'b0;
          beat_valid_nxt_s = 1'b1;
        end else if (beat_fire_s && beat_last_r) begin
          state_nxt_s      = S_IDLE;
          ready_nxt_s      = 1'b1;
          beat_valid_nxt_s = 1'b0;
        end else if (beat_fire_s) begin
          beat_addr_nxt_s  = next_addr_s;
          beat_strb_nxt_s  = next_strb_s;
          beat_idx_nxt_s   = next_idx_s;
          beat_last_nxt_s  = (next_idx_s == len_r);
        end else begin
          state_nxt_s      = S_BURST;
        end
      end
      default: begin
        state_nxt_s      = S_IDLE;
        ready_nxt_s      = 1'b0;
        beat_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything including cmd_ready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r      <= S_IDLE;
      ready_r      <= 1'b0;
      err_r        <= 1'b0;
      beat_valid_r <= 1'b0;
      beat_addr_r  <= {ADDRESS_WIDTH{1'b0}};
      beat_strb_r  <= {STRB_W{1'b0}};
      beat_idx_r   <= {LENGTH{1'b0}};
      beat_last_r  <= 1'b0;
      burst_r      <= 2'b00;
      size_r       <= 3'b000;
      len_r        <= {LENGTH{1'b0}};
      wrap_lower_r <= {ADDRESS_WIDTH{1'b0}};
      wrap_bound_r <= {ADDRESS_WIDTH{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      ready_r      <= ready_nxt_s;
      err_r        <= err_nxt_s;
      beat_valid_r <= beat_valid_nxt_s;
      beat_addr_r  <= beat_addr_nxt_s;
      beat_strb_r  <= beat_strb_nxt_s;
      beat_idx_r   <= beat_idx_nxt_s;
      beat_last_r  <= beat_last_nxt_s;
      burst_r      <= burst_nxt_s;
      size_r       <= size_nxt_s;
      len_r        <= len_nxt_s;
      wrap_lower_r <= wrap_lower_nxt_s;
      wrap_bound_r <= wrap_bound_nxt_s;
    end
  end

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// Testbench for axi4_burst_addr_gen (default parameters: 32-bit address,
// 32-bit data, 8-bit length). Directed vector table, hand-written
// back-to-back and mid-burst reset sequences, then random commands checked
// against a burst model computed from the AXI address rules.
// -----------------------------------------------------------------------------
module tb_axi4_burst_addr_gen;

  logic        aclk;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_addr;
  logic [3:0]  beat_strb;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic        cmd_err;
  logic        busy;

  axi4_burst_addr_gen #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .LENGTH       (8)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_size  (cmd_size),
    .cmd_burst (cmd_burst),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .beat_addr (beat_addr),
    .beat_strb (beat_strb),
    .beat_idx  (beat_idx),
    .beat_last (beat_last),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int n_checks = 0;
  int n_errors = 0;

  logic        exp_err;
  logic [31:0] exp_addr_q[$];
  logic [3:0]  exp_strb_q[$];

  typedef struct packed {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             err;
    logic [2:0]       nbeats;
    logic [3:0][31:0] a;
    logic [3:0][3:0]  s;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic err, input logic [2:0] nbeats,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3,
                         input logic [3:0] s0, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [3:0] s3);
    vec_t v;
    v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.err = err; v.nbeats = nbeats;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
    vecs.push_back(v);
  endtask

  // Reference model: list of beats a command should produce, from the AXI
  // address rules (WRAP computed as an offset modulo the window size).
  task automatic model(input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] bytes;
    logic [31:0] aligned;
    logic [31:0] wsize;
    logic [31:0] lower;
    logic [31:0] a;
    logic [3:0]  st;
    int          beats;
    int          lo;
    int          hi;
`ifdef AXI4_BURST_4KB_CHECK_EN
    logic [31:0] last_byte;
`endif
    bytes   = 32'd1 << size;
    aligned = addr - (addr % bytes);
    beats   = int'(len) + 1;
    exp_err = (burst == 2'b11) || (size > 3'd2) ||
              ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                     (len == 8'd7) || (len == 8'd15))) ||
              ((burst == 2'b10) && ((addr % bytes) != 32'd0));
`ifdef AXI4_BURST_4KB_CHECK_EN
    last_byte = aligned + 32'(beats) * bytes - 32'd1;
    if ((burst == 2'b01) && (last_byte[31:12] != addr[31:12])) exp_err = 1'b1;
`endif
    exp_addr_q.delete();
    exp_strb_q.delete();
    if (!exp_err) begin
      wsize = 32'(beats) * bytes;
      lower = addr - (addr % wsize);
      for (int n = 0; n < beats; n++) begin
        if (burst == 2'b00)      a = addr;
        else if (burst == 2'b01) a = (n == 0) ? addr : aligned + 32'(n) * bytes;
        else                     a = lower + (((addr - lower) + 32'(n) * bytes) % wsize);
        lo = int'(a % 32'd4);
        hi = int'((a - (a % bytes)) % 32'd4) + int'(bytes) - 1;
        st = 4'b0000;
        for (int l = 0; l < 4; l++) begin
          if ((l >= lo) && (l <= hi)) st[l] = 1'b1;
        end
        exp_addr_q.push_back(a);
        exp_strb_q.push_back(st);
      end
    end
  endtask

  // Asynchronous reset in the middle of a cycle while a burst is running.
  task automatic reset_mid_burst();
    #1 aresetn = 1'b0;
    #1;
    chk("rst_beat_valid", 32'(beat_valid), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_cmd_ready",  32'(cmd_ready),  32'd0);
    chk("rst_cmd_err",    32'(cmd_err),    32'd0);
    chk("rst_beat_addr",  beat_addr,       32'd0);
    chk("rst_beat_strb",  32'(beat_strb),  32'd0);
    chk("rst_beat_idx",   32'(beat_idx),   32'd0);
    chk("rst_beat_last",  32'(beat_last),  32'd0);
    beat_ready = 1'b0;
    @(posedge aclk);
    #2 aresetn = 1'b1;
    #1;
    chk("rel_cmd_ready_before_clk", 32'(cmd_ready), 32'd0);
    beat_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge aclk); #1;
      chk("rel_beat_valid", 32'(beat_valid), 32'd0);
      chk("rel_busy",       32'(busy),       32'd0);
      chk("rel_cmd_ready",  32'(cmd_ready),  32'd1);
    end
    beat_ready = 1'b0;
  endtask

  // Issue one command from idle and check its response against exp_*.
  // Called and returns one time unit after a rising edge.
  task automatic run_cmd(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int ready_pct, input int rst_at_idx);
    int n;
    int cyc;
    int nbeats;
    bit fire;
    nbeats     = exp_addr_q.size();
    cmd_addr   = addr;
    cmd_len    = len;
    cmd_size   = size;
    cmd_burst  = burst;
    cmd_valid  = 1'b1;
    beat_ready = 1'b0;
    @(negedge aclk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    if (exp_err) begin
      chk("cmd_err_pulse",      32'(cmd_err),    32'd1);
      chk("err_beat_valid",     32'(beat_valid), 32'd0);
      chk("err_busy",           32'(busy),       32'd0);
      chk("err_cmd_ready",      32'(cmd_ready),  32'd1);
      @(posedge aclk); #1;
      chk("cmd_err_one_cycle",  32'(cmd_err),    32'd0);
      chk("err_beat_valid_2",   32'(beat_valid), 32'd0);
      chk("err_cmd_ready_2",    32'(cmd_ready),  32'd1);
    end else begin
      chk("cmd_err_legal", 32'(cmd_err), 32'd0);
      n   = 0;
      cyc = 0;
      while ((n < nbeats) && (cyc < 400)) begin
        chk("beat_valid", 32'(beat_valid), 32'd1);
        chk("busy",       32'(busy),       32'd1);
        chk("beat_addr",  beat_addr,       exp_addr_q[n]);
        chk("beat_strb",  32'(beat_strb),  32'(exp_strb_q[n]));
        chk("beat_idx",   32'(beat_idx),   32'(n));
        chk("beat_last",  32'(beat_last),  32'(n == int'(len)));
        if (rst_at_idx == n) begin
          reset_mid_burst();
          return;
        end
        beat_ready = ($urandom_range(99) < ready_pct);
        @(negedge aclk);
        fire = beat_ready;
        chk("cmd_ready_burst", 32'(cmd_ready), 32'(fire && (n == nbeats - 1)));
        @(posedge aclk); #1;
        if (fire) n++;
        cyc++;
      end
      beat_ready = 1'b0;
      if (n < nbeats) begin
        chk("beat_timeout", 32'(n), 32'(nbeats));
      end else begin
        chk("end_beat_valid", 32'(beat_valid), 32'd0);
        chk("end_busy",       32'(busy),       32'd0);
        chk("end_cmd_ready",  32'(cmd_ready),  32'd1);
      end
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    int          sel;

    aresetn    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = 32'd0;
    cmd_len    = 8'd0;
    cmd_size   = 3'd0;
    cmd_burst  = 2'b00;
    beat_ready = 1'b0;

    //      addr        len    size  burst  err  n     beat addresses                                  strobes
    add_vec(32'h1002, 8'd3, 3'd2, 2'b01, 1'b0, 3'd4, 32'h1002, 32'h1004, 32'h1008, 32'h100C, 4'hC, 4'hF, 4'hF, 4'hF);
    add_vec(32'h0034, 8'd3, 3'd2, 2'b10, 1'b0, 3'd4, 32'h0034, 32'h0038, 32'h003C, 32'h0030, 4'hF, 4'hF, 4'hF, 4'hF);
    add_vec(32'h0101, 8'd2, 3'd0, 2'b00, 1'b0, 3'd3, 32'h0101, 32'h0101, 32'h0101, 32'h0,    4'h2, 4'h2, 4'h2, 4'h0);
    add_vec(32'h0003, 8'd2, 3'd1, 2'b01, 1'b0, 3'd3, 32'h0003, 32'h0004, 32'h0006, 32'h0,    4'h8, 4'h3, 4'hC, 4'h0);
    add_vec(32'h0007, 8'd1, 3'd0, 2'b10, 1'b0, 3'd2, 32'h0007, 32'h0006, 32'h0,    32'h0,    4'h8, 4'h4, 4'h0, 4'h0);
    add_vec(32'h001C, 8'd1, 3'd2, 2'b10, 1'b0, 3'd2, 32'h001C, 32'h0018, 32'h0,    32'h0,    4'hF, 4'hF, 4'h0, 4'h0);
    add_vec(32'h0200, 8'd0, 3'd2, 2'b01, 1'b0, 3'd1, 32'h0200, 32'h0,    32'h0,    32'h0,    4'hF, 4'h0, 4'h0, 4'h0);
    add_vec(32'h0000, 8'd0, 3'd0, 2'b11, 1'b1, 3'd0, 32'h0,    32'h0,    32'h0,    32'h0,    4'h0, 4'h0, 4'h0, 4'h0);
    add_vec(32'h0010, 8'd2, 3'd2, 2'b10, 1'b1, 3'd0, 32'h0,    32'h0,    32'h0,    32'h0,    4'h0, 4'h0, 4'h0, 4'h0);
    add_vec(32'h0000, 8'd1, 3'd3, 2'b01, 1'b1, 3'd0, 32'h0,    32'h0,    32'h0,    32'h0,    4'h0, 4'h0, 4'h0, 4'h0);
    add_vec(32'h0036, 8'd3, 3'd2, 2'b10, 1'b1, 3'd0, 32'h0,    32'h0,    32'h0,    32'h0,    4'h0, 4'h0, 4'h0, 4'h0);
`ifdef AXI4_BURST_4KB_CHECK_EN
    add_vec(32'h0FF8, 8'd3, 3'd2, 2'b01, 1'b1, 3'd0, 32'h0,    32'h0,    32'h0,    32'h0,    4'h0, 4'h0, 4'h0, 4'h0);
`else
    add_vec(32'h0FF8, 8'd3, 3'd2, 2'b01, 1'b0, 3'd4, 32'h0FF8, 32'h0FFC, 32'h1000, 32'h1004, 4'hF, 4'hF, 4'hF, 4'hF);
`endif

    // Reset values, then cmd_ready only after the first clock with reset high.
    #1;
    chk("reset_beat_valid", 32'(beat_valid), 32'd0);
    chk("reset_cmd_ready",  32'(cmd_ready),  32'd0);
    chk("reset_cmd_err",    32'(cmd_err),    32'd0);
    chk("reset_busy",       32'(busy),       32'd0);
    chk("reset_beat_addr",  beat_addr,       32'd0);
    chk("reset_beat_idx",   32'(beat_idx),   32'd0);
    #21 aresetn = 1'b1;
    #1;
    chk("cmd_ready_before_first_clk", 32'(cmd_ready), 32'd0);
    @(posedge aclk); #1;
    chk("cmd_ready_after_first_clk",  32'(cmd_ready), 32'd1);

    // Directed vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      exp_err = v.err;
      exp_addr_q.delete();
      exp_strb_q.delete();
      for (int b = 0; b < int'(v.nbeats); b++) begin
        exp_addr_q.push_back(v.a[b]);
        exp_strb_q.push_back(v.s[b]);
      end
      run_cmd(v.addr, v.len, v.size, v.burst, 70, -1);
    end

    // Back-to-back: FIXED burst, then INCR accepted during its last beat.
    cmd_addr = 32'h0101; cmd_len = 8'd2; cmd_size = 3'd0; cmd_burst = 2'b00;
    cmd_valid = 1'b1; beat_ready = 1'b1;
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("b2b_fixed_valid", 32'(beat_valid), 32'd1);
      chk("b2b_fixed_addr",  beat_addr,       32'h0101);
      chk("b2b_fixed_strb",  32'(beat_strb),  32'h2);
      chk("b2b_fixed_idx",   32'(beat_idx),   32'(k));
      if (k == 2) begin
        cmd_addr = 32'h0200; cmd_len = 8'd0; cmd_size = 3'd2; cmd_burst = 2'b01;
        cmd_valid = 1'b1;
        @(negedge aclk);
        chk("b2b_cmd_ready_last", 32'(cmd_ready), 32'd1);
      end else begin
        @(negedge aclk);
        chk("b2b_cmd_ready_mid", 32'(cmd_ready), 32'd0);
      end
      @(posedge aclk); #1;
    end
    cmd_valid = 1'b0;
    chk("b2b_incr_valid", 32'(beat_valid), 32'd1);
    chk("b2b_incr_addr",  beat_addr,       32'h0200);
    chk("b2b_incr_strb",  32'(beat_strb),  32'hF);
    chk("b2b_incr_idx",   32'(beat_idx),   32'd0);
    chk("b2b_incr_last",  32'(beat_last),  32'd1);
    chk("b2b_incr_err",   32'(cmd_err),    32'd0);
    @(posedge aclk); #1;
    beat_ready = 1'b0;
    chk("b2b_done_valid", 32'(beat_valid), 32'd0);
    chk("b2b_done_ready", 32'(cmd_ready),  32'd1);

    // INCR with 50% backpressure, reset asserted while beat 4 is presented.
    model(32'h0000, 8'd7, 3'd2, 2'b01);
    run_cmd(32'h0000, 8'd7, 3'd2, 2'b01, 50, 4);

    // Random commands against the model.
    for (int t = 0; t < 80; t++) begin
      sel = int'($urandom_range(9));
      if (sel < 2)      r_burst = 2'b00;
      else if (sel < 6) r_burst = 2'b01;
      else if (sel < 9) r_burst = 2'b10;
      else              r_burst = 2'b11;
      r_size = ($urandom_range(11) == 0) ? 3'd3 : 3'($urandom_range(2));
      if (r_burst == 2'b10) begin
        sel = int'($urandom_range(9));
        r_len = (sel == 0) ? 8'd2 : (8'd1 << (2'($urandom_range(3)) + 1)) - 8'd1;
      end else begin
        r_len = 8'($urandom_range(15));
      end
      r_addr = 32'($urandom_range(32'h3FFF));
      if ((r_burst == 2'b10) && ($urandom_range(9) != 0)) begin
        r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      end
      model(r_addr, r_len, r_size, r_burst);
      run_cmd(r_addr, r_len, r_size, r_burst, int'($urandom_range(100, 40)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
